// File: rtl/exu_div_pkg.sv
// Shared encodings and helpers for the EXU divider control front-end.
// Controller FSM states, RV64M divide op encodings and 32-to-64 sign extension.
package exu_div_pkg;

   localparam logic [1:0] DIV_OP_DIV  = 2'b00;
   localparam logic [1:0] DIV_OP_DIVU = 2'b01;
   localparam logic [1:0] DIV_OP_REM  = 2'b10;
   localparam logic [1:0] DIV_OP_REMU = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } div_state_t;

   function automatic logic [63:0] sext32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

endpackage

// File: rtl/exu_div_ctrl_if.sv
// Issue, writeback and divider-core signal bundle of exu_div_ctrl.
// slave = the controller, master = its surroundings (EXU issue, writeback, core).
interface exu_div_ctrl_if #(
   parameter int TAG_W = 5,
   parameter int XLEN  = 64
);
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_op;
   logic             in_word;
   logic [XLEN-1:0]  in_rs1;
   logic [XLEN-1:0]  in_rs2;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_data;
   logic [TAG_W-1:0] out_tag;
   logic             div_valid;
   logic             div_ready;
   logic             div_flush;
   logic             div_divw;
   logic [1:0]       div_signed;
   logic [XLEN-1:0]  div_dividend;
   logic [XLEN-1:0]  div_divisor;
   logic             div_out_valid;
   logic [XLEN-1:0]  div_quotient;
   logic [XLEN-1:0]  div_remainder;

   modport slave (
      input  flush, in_valid, in_op, in_word, in_rs1, in_rs2, in_tag, out_ready,
             div_ready, div_out_valid, div_quotient, div_remainder,
      output in_ready, out_valid, out_data, out_tag,
             div_valid, div_flush, div_divw, div_signed, div_dividend, div_divisor
   );

   modport master (
      output flush, in_valid, in_op, in_word, in_rs1, in_rs2, in_tag, out_ready,
             div_ready, div_out_valid, div_quotient, div_remainder,
      input  in_ready, out_valid, out_data, out_tag,
             div_valid, div_flush, div_divw, div_signed, div_dividend, div_divisor
   );
endinterface

// File: rtl/exu_div_special.sv
// Combinational divide-by-zero / signed-overflow detection and their architectural result.
// W variants use the low 32 bits of each operand and return a sign-extended 32-bit result.
module exu_div_special
   import exu_div_pkg::*;
(
   input  logic [63:0] a,
   input  logic [63:0] b,
   input  logic        word,
   input  logic        is_signed,
   input  logic        is_rem,
   output logic        zero_div,
   output logic        overflow,
   output logic        special,
   output logic [63:0] result
);
   logic [63:0] a_eff;
   logic [63:0] b_eff;
   logic [63:0] min_neg;
   logic [63:0] quot;
   logic [63:0] rem;
   logic [63:0] sel;

   // Sign-extending the W operands lets one set of 64-bit compares serve both widths.
   assign a_eff    = word ? sext32(a[31:0]) : a;
   assign b_eff    = word ? sext32(b[31:0]) : b;
   assign min_neg  = word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;

   assign zero_div = (b_eff == 64'd0);
   assign overflow = is_signed & (b_eff == 64'hFFFF_FFFF_FFFF_FFFF) & (a_eff == min_neg);
   assign special  = zero_div | overflow;

   assign quot     = zero_div ? 64'hFFFF_FFFF_FFFF_FFFF : a_eff;
   assign rem      = zero_div ? a_eff : 64'd0;
   assign sel      = is_rem ? rem : quot;
   assign result   = word ? sext32(sel[31:0]) : sel;
endmodule

// File: rtl/exu_div_ctrl.sv
// Divider control front-end: decodes RV64M DIV/REM(+W), resolves special cases locally,
// launches the radix-2 core otherwise and holds the result under writeback backpressure.
// Optional macro DIV_RESULT_CACHE_EN adds a 1-entry cache of the last core completion.
module exu_div_ctrl
   import exu_div_pkg::*;
#(
   parameter int TAG_W = 5,
   parameter int XLEN  = 64
)(
   input logic          clk,
   input logic          rst,
   exu_div_ctrl_if.slave bus
);
   div_state_t       state_r, state_s;
   logic             is_rem_r, signed_r, word_r;
   logic [XLEN-1:0]  rs1_r, rs2_r;
   logic [TAG_W-1:0] tag_r;
   logic [XLEN-1:0]  out_data_r;
   logic [TAG_W-1:0] out_tag_r;

   logic             in_ready_s, accept_s, in_is_rem_s, in_signed_s;
   logic             spec_hit_s, spec_zero_s, spec_ovf_s, cache_hit_s, fast_s, capture_s;
   logic [XLEN-1:0]  spec_result_s, cache_result_s, fast_result_s, core_sel_s, core_result_s;

   assign in_ready_s  = (state_r == IDLE) & ~bus.flush & ~rst;
   assign accept_s    = bus.in_valid & in_ready_s;
   assign in_is_rem_s = bus.in_op[1];
   assign in_signed_s = ~bus.in_op[0];

   exu_div_special u_special (
      .a         (bus.in_rs1),
      .b         (bus.in_rs2),
      .word      (bus.in_word),
      .is_signed (in_signed_s),
      .is_rem    (in_is_rem_s),
      .zero_div  (spec_zero_s),
      .overflow  (spec_ovf_s),
      .special   (spec_hit_s),
      .result    (spec_result_s)
   );

`ifdef DIV_RESULT_CACHE_EN
   logic             cache_valid_r, cache_word_r, cache_signed_r;
   logic [XLEN-1:0]  cache_rs1_r, cache_rs2_r, cache_q_r, cache_r_r;
   logic [XLEN-1:0]  cache_sel_s;

   assign cache_hit_s    = cache_valid_r & (cache_rs1_r == bus.in_rs1) & (cache_rs2_r == bus.in_rs2)
                         & (cache_word_r == bus.in_word) & (cache_signed_r == in_signed_s);
   assign cache_sel_s    = in_is_rem_s ? cache_r_r : cache_q_r;
   assign cache_result_s = bus.in_word ? sext32(cache_sel_s[31:0]) : cache_sel_s;

   // Result cache: refilled on every captured core completion, survives flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         cache_valid_r  <= 1'b0;
         cache_word_r   <= 1'b0;
         cache_signed_r <= 1'b0;
         cache_rs1_r    <= {XLEN{1'b0}};
         cache_rs2_r    <= {XLEN{1'b0}};
         cache_q_r      <= {XLEN{1'b0}};
         cache_r_r      <= {XLEN{1'b0}};
      end else if (capture_s) begin
         cache_valid_r  <= 1'b1;
         cache_word_r   <= word_r;
         cache_signed_r <= signed_r;
         cache_rs1_r    <= rs1_r;
         cache_rs2_r    <= rs2_r;
         cache_q_r      <= bus.div_quotient;
         cache_r_r      <= bus.div_remainder;
      end
   end
`else
   assign cache_hit_s    = 1'b0;
   assign cache_result_s = {XLEN{1'b0}};
`endif

   assign fast_s        = spec_hit_s | cache_hit_s;
   assign fast_result_s = spec_hit_s ? spec_result_s : cache_result_s;
   assign capture_s     = (state_r == WAIT) & bus.div_out_valid & ~bus.flush;
   assign core_sel_s    = is_rem_r ? bus.div_remainder : bus.div_quotient;
   assign core_result_s = word_r ? sext32(core_sel_s[31:0]) : core_sel_s;

   // Next-state logic; flush overrides every transition.
   always_comb begin
      state_s = state_r;
      if (bus.flush) begin
         state_s = IDLE;
      end else begin
         case (state_r)
            IDLE:    if (accept_s) state_s = fast_s ? RESP : ISSUE; else state_s = IDLE;
            ISSUE:   if (bus.div_ready) state_s = WAIT; else state_s = ISSUE;
            WAIT:    if (bus.div_out_valid) state_s = RESP; else state_s = WAIT;
            RESP:    if (bus.out_ready) state_s = IDLE; else state_s = RESP;
            default: state_s = IDLE;
         endcase
      end
   end

   // State, captured operation and held result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         is_rem_r   <= 1'b0;
         signed_r   <= 1'b0;
         word_r     <= 1'b0;
         rs1_r      <= {XLEN{1'b0}};
         rs2_r      <= {XLEN{1'b0}};
         tag_r      <= {TAG_W{1'b0}};
         out_data_r <= {XLEN{1'b0}};
         out_tag_r  <= {TAG_W{1'b0}};
      end else begin
         state_r <= state_s;
         if (accept_s) begin
            is_rem_r <= in_is_rem_s;
            signed_r <= in_signed_s;
            word_r   <= bus.in_word;
            rs1_r    <= bus.in_rs1;
            rs2_r    <= bus.in_rs2;
            tag_r    <= bus.in_tag;
         end
         if (accept_s && fast_s) begin
            out_data_r <= fast_result_s;
            out_tag_r  <= bus.in_tag;
         end else if (capture_s) begin
            out_data_r <= core_result_s;
            out_tag_r  <= tag_r;
         end
      end
   end

   assign bus.in_ready     = in_ready_s;
   assign bus.out_valid    = (state_r == RESP);
   assign bus.out_data     = out_data_r;
   assign bus.out_tag      = out_tag_r;
   assign bus.div_valid    = (state_r == ISSUE);
   assign bus.div_flush    = bus.flush | rst;
   assign bus.div_divw     = word_r;
   assign bus.div_signed   = {2{signed_r}};
   assign bus.div_dividend = rs1_r;
   assign bus.div_divisor  = rs2_r;
endmodule
